call_sequencer: RTL and testbench

- Program-counter and call/return controller for the small CPU core.
- Decodes per-cycle flow ops (jump, branch, call, return) and drives the external return-address stack's push/pop strobes.
- Tracks stack depth, so overflow and underflow are caught before the stack is corrupted.
- Sits between the instruction decoder and the return-address stack.

---
 rtl/call_sequencer_if.sv | 32 +++
 rtl/call_sequencer.sv | 119 +++++++++++
 tb/tb_call_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/call_sequencer_if.sv
// Decoder/stack-side bundle for call_sequencer: flow-op request, PC and return-address stack strobes.
interface call_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 3
);
  localparam int DW = $clog2(DEPTH + 1);

  logic              en;
  logic [2:0]        op;
  logic [ADDR_W-1:0] target;
  logic              cond;
  logic [ADDR_W-1:0] pc;
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_wdata;
  logic [ADDR_W-1:0] stk_rdata;
  logic [DW-1:0]     depth;
  logic              bubble;
  logic              ovf;
  logic              unf;
  logic              fault;

  modport master (
    output en, op, target, cond, stk_rdata,
    input  pc, stk_push, stk_pop, stk_wdata, depth, bubble, ovf, unf, fault
  );

  modport slave (
    input  en, op, target, cond, stk_rdata,
    output pc, stk_push, stk_pop, stk_wdata, depth, bubble, ovf, unf, fault
  );
endinterface

// File: rtl/call_sequencer.sv
// PC and call/return controller driving an external return-address stack.
// Optional STACK_FAULT_HALT_EN: stack overflow/underflow halts in FAULT instead of acting as NOP.
//
// state       | meaning
// S_RUN       | normal execution of flow ops
// S_RET_FLUSH | one bubble cycle after a RET; pc holds, op ignored
// S_FAULT     | stack misuse trapped; everything frozen until rst
module call_sequencer #(
  parameter int          ADDR_W   = 11,
  parameter int          DEPTH    = 3,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst,
  call_sequencer_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_BRZ  = 3'b100;
  localparam logic [2:0] OP_BRNZ = 3'b101;

  typedef enum logic [1:0] {S_RUN, S_RET_FLUSH, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push, pop;

  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= ADDR_W'(RESET_PC);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (bus.en) begin
      case (state_q)
        S_RUN: begin
          case (bus.op)
            OP_JMP:  pc_d = bus.target;
            OP_CALL: begin
              if (depth_q != DEPTH_MAX) begin
                push    = 1'b1;
                pc_d    = bus.target;
                depth_d = depth_q + DW'(1);
              end else begin
                ovf_d = 1'b1;
`ifdef STACK_FAULT_HALT_EN
                state_d = S_FAULT;
`else
                pc_d = pc_inc;
`endif
              end
            end
            OP_RET: begin
              if (depth_q != '0) begin
                pop     = 1'b1;
                pc_d    = bus.stk_rdata;
                depth_d = depth_q - DW'(1);
                state_d = S_RET_FLUSH;
              end else begin
                unf_d = 1'b1;
`ifdef STACK_FAULT_HALT_EN
                state_d = S_FAULT;
`else
                pc_d = pc_inc;
`endif
              end
            end
            OP_BRZ:  pc_d = bus.cond ? bus.target : pc_inc;
            OP_BRNZ: pc_d = bus.cond ? pc_inc : bus.target;
            default: pc_d = pc_inc;
          endcase
        end
        S_RET_FLUSH: state_d = S_RUN;
        default: ;
      endcase
    end
  end

  // Strobes are combinational, so gate them with rst to keep them low during reset.
  assign bus.stk_push  = push & ~rst;
  assign bus.stk_pop   = pop & ~rst;
  assign bus.stk_wdata = pc_inc;
  assign bus.pc        = pc_q;
  assign bus.depth     = depth_q;
  assign bus.bubble    = (state_q == S_RET_FLUSH);
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
`ifdef STACK_FAULT_HALT_EN
  assign bus.fault     = (state_q == S_FAULT);
`else
  assign bus.fault     = 1'b0;
`endif
endmodule

// File: tb/tb_call_sequencer.sv
// Self-checking bench for call_sequencer: directed scenarios plus randomized ops against a queue-based stack model.
module tb_call_sequencer;
  localparam int AW  = 11;
  localparam int DP  = 3;
  localparam int DW  = $clog2(DP + 1);
  localparam int MOD = 1 << AW;
`ifdef STACK_FAULT_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  call_sequencer_if #(.ADDR_W(AW), .DEPTH(DP)) bus ();

  call_sequencer #(.ADDR_W(AW), .DEPTH(DP), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pc as an integer, the return stack as a queue.
  int m_pc;
  int m_stack[$];
  bit m_flush, m_fault, m_ovf, m_unf;
  bit exp_push, exp_pop;
  int exp_wdata;
  logic obs_push, obs_pop;
  logic [AW-1:0] obs_wdata;

  function automatic int inc(int p);
    return (p + 1) % MOD;
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_flush = 0; m_fault = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(bit e, bit [2:0] o, int t, bit c);
    exp_push  = 0;
    exp_pop   = 0;
    exp_wdata = inc(m_pc);
    if (!e || m_fault) return;
    if (m_flush) begin m_flush = 0; return; end
    case (o)
      3'd1: m_pc = t;
      3'd2: begin
        if (m_stack.size() < DP) begin
          exp_push = 1;
          m_stack.push_back(inc(m_pc));
          m_pc = t;
        end else begin
          m_ovf = 1;
          if (HALT) m_fault = 1; else m_pc = inc(m_pc);
        end
      end
      3'd3: begin
        if (m_stack.size() > 0) begin
          exp_pop = 1;
          m_pc = m_stack.pop_back();
          m_flush = 1;
        end else begin
          m_unf = 1;
          if (HALT) m_fault = 1; else m_pc = inc(m_pc);
        end
      end
      3'd4: m_pc = c ? t : inc(m_pc);
      3'd5: m_pc = c ? inc(m_pc) : t;
      default: m_pc = inc(m_pc);
    endcase
  endtask

  task automatic sample_strobes();
    obs_push  = bus.stk_push;
    obs_pop   = bus.stk_pop;
    obs_wdata = bus.stk_wdata;
  endtask

  task automatic step(bit e, bit [2:0] o, int t, bit c);
    @(negedge clk);
    rst = 1'b0;
    bus.en = e; bus.op = o; bus.target = AW'(t); bus.cond = c;
    bus.stk_rdata = (m_stack.size() > 0) ? AW'(m_stack[$]) : AW'($urandom);
    #1;
    sample_strobes();
    model_step(e, o, t, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(bit e, bit [2:0] o);
    @(negedge clk);
    rst = 1'b1;
    bus.en = e; bus.op = o; bus.target = AW'($urandom); bus.cond = 1'($urandom);
    bus.stk_rdata = AW'($urandom);
    #1;
    sample_strobes();
    exp_push = 0; exp_pop = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 3'd2);
    n_cmp++;
    if (bus.pc !== 11'h000) begin n_err++; $display("FAIL reset_pc got=%h want=000", bus.pc); end
    n_cmp++;
    if ({bus.depth, bus.bubble, bus.ovf, bus.unf, bus.fault} !== '0) begin
      n_err++; $display("FAIL reset_state got depth=%0d b=%b o=%b u=%b f=%b want all 0",
                        bus.depth, bus.bubble, bus.ovf, bus.unf, bus.fault);
    end
    n_cmp++;
    if ({obs_push, obs_pop} !== 2'b00) begin
      n_err++; $display("FAIL reset_strobes got push=%b pop=%b want 0 0", obs_push, obs_pop);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1, 3'd0, 0, 0);
      n_cmp++;
      if (bus.pc !== AW'(i) || bus.depth !== '0 || obs_push || obs_pop) begin
        n_err++; $display("FAIL nop_seq got pc=%h depth=%0d push=%b pop=%b want pc=%h depth=0 no strobes",
                          bus.pc, bus.depth, obs_push, obs_pop, AW'(i));
      end
    end
  endtask

  task automatic test_call_ret();
    do_reset(1'b0, 3'd0);
    step(1, 3'd1, 'h010, 0);
    step(1, 3'd2, 'h200, 0);
    n_cmp++;
    if (obs_push !== 1'b1 || obs_pop !== 1'b0 || obs_wdata !== 11'h011) begin
      n_err++; $display("FAIL call_strobe got push=%b pop=%b wdata=%h want 1 0 011", obs_push, obs_pop, obs_wdata);
    end
    n_cmp++;
    if (bus.pc !== 11'h200 || bus.depth !== DW'(1)) begin
      n_err++; $display("FAIL call_pc got pc=%h depth=%0d want 200 1", bus.pc, bus.depth);
    end
    step(1, 3'd3, 'h555, 0);
    n_cmp++;
    if (obs_pop !== 1'b1 || obs_push !== 1'b0) begin
      n_err++; $display("FAIL ret_strobe got pop=%b push=%b want 1 0", obs_pop, obs_push);
    end
    n_cmp++;
    if (bus.pc !== 11'h011 || bus.bubble !== 1'b1 || bus.depth !== '0) begin
      n_err++; $display("FAIL ret_pc got pc=%h bubble=%b depth=%0d want 011 1 0", bus.pc, bus.bubble, bus.depth);
    end
    step(1, 3'd1, 'h3AA, 0);
    n_cmp++;
    if (bus.pc !== 11'h011 || bus.bubble !== 1'b0 || obs_push || obs_pop) begin
      n_err++; $display("FAIL flush_cycle got pc=%h bubble=%b push=%b pop=%b want 011 0 0 0",
                        bus.pc, bus.bubble, obs_push, obs_pop);
    end
    step(1, 3'd0, 0, 0);
    n_cmp++;
    if (bus.pc !== 11'h012) begin n_err++; $display("FAIL after_flush got pc=%h want 012", bus.pc); end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] want;
    do_reset(1'b0, 3'd0);
    step(1, 3'd2, 'h100, 0);
    step(1, 3'd2, 'h200, 0);
    step(1, 3'd2, 'h300, 0);
    step(1, 3'd2, 'h444, 0);
    n_cmp++;
    if (obs_push !== 1'b0 || bus.ovf !== 1'b1 || bus.depth !== DW'(3)) begin
      n_err++; $display("FAIL ovf got push=%b ovf=%b depth=%0d want 0 1 3", obs_push, bus.ovf, bus.depth);
    end
    want = HALT ? 11'h300 : 11'h301;
    n_cmp++;
    if (bus.pc !== want || bus.fault !== HALT) begin
      n_err++; $display("FAIL ovf_pc got pc=%h fault=%b want %h %b", bus.pc, bus.fault, want, HALT);
    end
    step(1, 3'd1, 'h123, 0);
    want = HALT ? 11'h300 : 11'h123;
    n_cmp++;
    if (bus.pc !== want || bus.ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_after got pc=%h ovf=%b want %h 1", bus.pc, bus.ovf, want);
    end
  endtask

  task automatic test_underflow();
    logic [AW-1:0] want;
    do_reset(1'b0, 3'd0);
    step(1, 3'd3, 'h222, 0);
    want = HALT ? 11'h000 : 11'h001;
    n_cmp++;
    if (obs_pop !== 1'b0 || bus.unf !== 1'b1 || bus.pc !== want || bus.fault !== HALT || bus.bubble !== 1'b0) begin
      n_err++; $display("FAIL unf got pop=%b unf=%b pc=%h fault=%b bubble=%b want 0 1 %h %b 0",
                        obs_pop, bus.unf, bus.pc, bus.fault, bus.bubble, want, HALT);
    end
    do_reset(1'b1, 3'd3);
    n_cmp++;
    if (bus.unf !== 1'b0 || bus.fault !== 1'b0 || bus.pc !== 11'h000) begin
      n_err++; $display("FAIL unf_clear got unf=%b fault=%b pc=%h want 0 0 000", bus.unf, bus.fault, bus.pc);
    end
  endtask

  task automatic test_wrap_branch();
    do_reset(1'b0, 3'd0);
    step(1, 3'd1, 'h7FF, 0);
    step(1, 3'd0, 0, 0);
    n_cmp++;
    if (bus.pc !== 11'h000) begin n_err++; $display("FAIL wrap got pc=%h want 000", bus.pc); end
    step(1, 3'd4, 'h050, 1);
    n_cmp++;
    if (bus.pc !== 11'h050) begin n_err++; $display("FAIL brz_taken got pc=%h want 050", bus.pc); end
    step(1, 3'd5, 'h600, 1);
    n_cmp++;
    if (bus.pc !== 11'h051) begin n_err++; $display("FAIL brnz_not got pc=%h want 051", bus.pc); end
    step(1, 3'd5, 'h123, 0);
    n_cmp++;
    if (bus.pc !== 11'h123) begin n_err++; $display("FAIL brnz_taken got pc=%h want 123", bus.pc); end
    step(1, 3'd4, 'h700, 0);
    n_cmp++;
    if (bus.pc !== 11'h124) begin n_err++; $display("FAIL brz_not got pc=%h want 124", bus.pc); end
    step(1, 3'd1, 'h7FF, 0);
    step(1, 3'd2, 'h010, 0);
    n_cmp++;
    if (obs_wdata !== 11'h000 || obs_push !== 1'b1) begin
      n_err++; $display("FAIL wdata_wrap got wdata=%h push=%b want 000 1", obs_wdata, obs_push);
    end
  endtask

  task automatic test_flush_hold();
    do_reset(1'b0, 3'd0);
    step(1, 3'd2, 'h040, 0);
    step(1, 3'd3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'($urandom), $urandom_range(0, MOD - 1), 1'($urandom));
      n_cmp++;
      if (bus.pc !== 11'h001 || bus.bubble !== 1'b1 || obs_push || obs_pop) begin
        n_err++; $display("FAIL flush_hold got pc=%h bubble=%b push=%b pop=%b want 001 1 0 0",
                          bus.pc, bus.bubble, obs_push, obs_pop);
      end
    end
    do_reset(1'b1, 3'd2);
    n_cmp++;
    if (bus.pc !== 11'h000 || bus.depth !== '0 || {bus.bubble, bus.ovf, bus.unf, bus.fault} !== 4'b0 ||
        obs_push || obs_pop) begin
      n_err++; $display("FAIL flush_rst got pc=%h depth=%0d b=%b o=%b u=%b f=%b push=%b want all 0",
                        bus.pc, bus.depth, bus.bubble, bus.ovf, bus.unf, bus.fault, obs_push);
    end
    step(1, 3'd0, 0, 0);
    n_cmp++;
    if (bus.pc !== 11'h001 || bus.bubble !== 1'b0) begin
      n_err++; $display("FAIL post_rst_run got pc=%h bubble=%b want 001 0", bus.pc, bus.bubble);
    end
  endtask

  task automatic test_random();
    do_reset(1'b0, 3'd0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0 || (m_fault && $urandom_range(0, 3) == 0)) begin
        do_reset(1'($urandom), 3'($urandom));
      end else begin
        step($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, MOD - 1), 1'($urandom));
      end
      n_cmp++;
      if (obs_push !== exp_push || obs_pop !== exp_pop || (exp_push && obs_wdata !== AW'(exp_wdata))) begin
        n_err++; $display("FAIL rnd_strobe i=%0d got push=%b pop=%b wdata=%h want %b %b %h",
                          i, obs_push, obs_pop, obs_wdata, exp_push, exp_pop, AW'(exp_wdata));
      end
      n_cmp++;
      if (bus.pc !== AW'(m_pc) || bus.depth !== DW'(m_stack.size())) begin
        n_err++; $display("FAIL rnd_pc i=%0d got pc=%h depth=%0d want %h %0d",
                          i, bus.pc, bus.depth, AW'(m_pc), m_stack.size());
      end
      n_cmp++;
      if ({bus.bubble, bus.ovf, bus.unf, bus.fault} !== {m_flush, m_ovf, m_unf, m_fault}) begin
        n_err++; $display("FAIL rnd_flags i=%0d got b/o/u/f=%b want %b", i,
                          {bus.bubble, bus.ovf, bus.unf, bus.fault}, {m_flush, m_ovf, m_unf, m_fault});
      end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.op = 3'd0; bus.target = '0; bus.cond = 1'b0; bus.stk_rdata = '0;
    model_reset();
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap_branch();
    test_flush_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
